// File: rtl/vec_wb_buffer.sv
// ============================================================================
// Module   : vec_wb_buffer
// Purpose  : 2-entry in-order buffer between ALU_vec and vector writeback.
//            Optional sticky flag accumulator enabled by macro VEC_WB_STICKY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_wb_buffer #(
    parameter int DATA_W = 256,
    parameter int FLAG_W = 64,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we,
    output logic [1:0]        count,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              sticky_clr
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              w_push;
    logic              w_pop;
    logic              w_load_head;
    logic              w_load_tail;
    logic              w_promote;

    logic [DATA_W-1:0] r_head_result, r_tail_result;
    logic [FLAG_W-1:0] r_head_flags,  r_tail_flags;
    logic [RD_W-1:0]   r_head_rd,     r_tail_rd;
    logic              r_head_we,     r_tail_we;

    // Handshake depends only on registered state; no out_ready -> in_ready path.
    assign in_ready  = (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign count     = 2'(r_state);

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_promote   = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = S_ONE;
                        w_load_head = 1'b1;
                    end
                end
                S_ONE: begin
                    case ({w_push, w_pop})
                        2'b11:   w_load_head = 1'b1;
                        2'b10: begin
                            w_state_nxt = S_FULL;
                            w_load_tail = 1'b1;
                        end
                        2'b01:   w_state_nxt = S_EMPTY;
                        default: w_state_nxt = S_ONE;
                    endcase
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_state_nxt = S_ONE;
                        w_promote   = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_result <= '0;
            r_head_flags  <= '0;
            r_head_rd     <= '0;
            r_head_we     <= 1'b0;
            r_tail_result <= '0;
            r_tail_flags  <= '0;
            r_tail_rd     <= '0;
            r_tail_we     <= 1'b0;
        end else begin
            if (w_load_head) begin
                r_head_result <= in_result;
                r_head_flags  <= in_flags;
                r_head_rd     <= in_rd;
                r_head_we     <= in_we;
            end else if (w_promote) begin
                r_head_result <= r_tail_result;
                r_head_flags  <= r_tail_flags;
                r_head_rd     <= r_tail_rd;
                r_head_we     <= r_tail_we;
            end
            if (w_load_tail) begin
                r_tail_result <= in_result;
                r_tail_flags  <= in_flags;
                r_tail_rd     <= in_rd;
                r_tail_we     <= in_we;
            end
        end
    end

    assign out_result = r_head_result;
    assign out_flags  = r_head_flags;
    assign out_rd     = r_head_rd;
    assign out_we     = r_head_we;

`ifdef VEC_WB_STICKY_EN
    logic [FLAG_W-1:0] r_sticky;
    logic              w_retire;

    // A flush edge ignores the pop, so nothing retires on that edge.
    assign w_retire = w_pop & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sticky <= '0;
        end else if (sticky_clr) begin
            r_sticky <= w_retire ? r_head_flags : '0;
        end else if (w_retire) begin
            r_sticky <= r_sticky | r_head_flags;
        end
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused_sticky_clr;

    assign w_unused_sticky_clr = sticky_clr;
    assign sticky_flags        = '0;
`endif

endmodule

`default_nettype wire

// File: doc/vec_wb_buffer.md
VEC_WB_BUFFER -- requirements
Module: vec_wb_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 256, vector result width in bits (one ALU_vec result).
REQ-002 SHALL have parameter FLAG_W, default 64, per-lane flag vector width in bits.
REQ-003 SHALL have parameter RD_W, default 4, destination vector register index width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  ALU_vec result valid this cycle.
- in_ready  out  1  buffer can accept an entry.
- in_result  in  DATA_W  ALU_vec result.
- in_flags  in  FLAG_W  ALU_vec flags.
- in_rd  in  RD_W  destination register.
- in_we  in  1  entry writes the register file.
- flush  in  1  discard all held entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback consumes the head.
- out_result  out  DATA_W  head result.
- out_flags  out  FLAG_W  head flags.
- out_rd  out  RD_W  head destination.
- out_we  out  1  head write enable.
- count  out  2  number of held entries (0..2).
- sticky_flags  out  FLAG_W  OR of flags of all retired entries.
- sticky_clr  in  1  clear sticky_flags.

Function
REQ-005 SHALL be a 2-entry in-order buffer between ALU_vec and vector writeback, with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-006 SHALL accept an entry (push) on a rising edge where in_valid=1 and in_ready=1, and retire the head (pop) on a rising edge where out_valid=1 and out_ready=1.
REQ-007 SHALL drive in_ready = (count != 2) from registered state only, with no combinational path from out_ready.
REQ-008 SHALL have a push-to-output latency of 1 cycle: an entry pushed into EMPTY appears on out_* with out_valid=1 in the next cycle.
REQ-009 SHALL drive out_valid = (count != 0); out_result, out_flags, out_rd and out_we SHALL come from the head register and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-010 SHALL make the following state transitions:
- EMPTY+push -> ONE.
- ONE+push without pop -> FULL.
- ONE+pop without push -> EMPTY.
- ONE+push+pop -> ONE, with the new entry at the head.
- FULL+pop -> ONE, with the second entry promoted to the head.
- Push is impossible in FULL.
REQ-011 SHALL preserve order; an entry pushed while the buffer holds one entry is never presented before that entry.
REQ-012 SHALL, when flush=1 on an edge, set count to 0 and ignore any push and pop on that edge; in_ready SHALL be 1 in the following cycle.
REQ-013 SHALL pass in_result, in_flags, in_rd and in_we unmodified, without lane reordering or truncation.
REQ-014 SHALL leave the payload registers of an invalid slot don't-care; the bench SHALL NOT check out_result, out_flags, out_rd or out_we while out_valid=0.

Reset
REQ-015 SHALL, while rst=0, immediately force the state to EMPTY: count=0, out_valid=0, in_ready=1, sticky_flags=0, out_result=0, out_flags=0, out_rd=0, out_we=0.
REQ-016 SHALL, on reset assertion mid-operation, discard all entries and the sticky state with no partial retire; the first push after reset deassertion SHALL behave as a push into EMPTY.

Configuration
REQ-017 SHALL compile the sticky flag accumulator when macro VEC_WB_STICKY_EN is defined: on each pop, sticky_flags <= sticky_flags | out_flags.
REQ-018 SHALL, with VEC_WB_STICKY_EN defined, clear sticky_flags on an edge with sticky_clr=1; when sticky_clr=1 and a pop coincide, sticky_flags SHALL become exactly the popped out_flags. Flush SHALL NOT affect sticky_flags.
REQ-019 SHALL, without VEC_WB_STICKY_EN, tie sticky_flags to 0, ignore sticky_clr and instantiate no accumulator registers.

Verification
REQ-020 SHALL cover a single pass: push result=256'h1234..CDEF, flags=64'h5, rd=3, we=1 with out_ready=1 -> next cycle out_valid=1 with the identical payload, then count=0.
REQ-021 SHALL cover backpressure: out_ready=0, push A (rd=1) then B (rd=2) -> count=2, in_ready=0, out_rd=1 held; out_ready=1 -> out_rd=1 then out_rd=2, and in_ready=1 after the first pop.
REQ-022 SHALL cover simultaneous events: with count=1 (A), push C and pop A on the same edge -> count=1, out_rd=C.rd.
REQ-023 SHALL cover flush with push: count=2 and flush=1 with in_valid=1 on the same edge -> count=0, out_valid=0, in_ready=1 next cycle.
REQ-024 SHALL cover sticky flags with VEC_WB_STICKY_EN: retire flags 64'h1 then 64'h4 -> sticky=64'h5; sticky_clr with a pop of 64'h8 -> sticky=64'h8; without the macro sticky=0 throughout.
REQ-025 SHALL cover asynchronous reset: rst=0 mid-cycle with count=2 -> out_valid=0, count=0, sticky_flags=0 before the next edge.
